// File: rtl/instr_fetch_reg.sv
// Instruction fetch and instruction register stage: fetches one word at pc over a
// req/ack memory handshake, holds it, and exposes the decoded instruction fields.
module instr_fetch_reg #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              busy,
  output logic              done,
  output logic              instr_valid,
  output logic              fetch_err,
  output logic [DATA_W-1:0] instr,
  output logic [5:0]        opcode,
  output logic [4:0]        rs,
  output logic [4:0]        rt,
  output logic [4:0]        rd,
  output logic [4:0]        shamt,
  output logic [5:0]        funct,
  output logic [15:0]       imm16,
  output logic [25:0]       jaddr
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } fetchState_e;

  fetchState_e       state, stateNext;
  logic [ADDR_W-1:0] memAddrNext;
  logic              memRdNext, busyNext, doneNext, validNext, errNext;
  logic [DATA_W-1:0] instrNext;
  logic [CNT_W-1:0]  waitCnt, waitCntNext;

  // State and all registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      mem_addr    <= '0;
      mem_rd      <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      instr_valid <= 1'b0;
      fetch_err   <= 1'b0;
      instr       <= '0;
      waitCnt     <= '0;
    end else begin
      state       <= stateNext;
      mem_addr    <= memAddrNext;
      mem_rd      <= memRdNext;
      busy        <= busyNext;
      done        <= doneNext;
      instr_valid <= validNext;
      fetch_err   <= errNext;
      instr       <= instrNext;
      waitCnt     <= waitCntNext;
    end
  end

  // Next-state and next-output logic; done is a pulse so it defaults low
  always_comb begin
    stateNext   = state;
    memAddrNext = mem_addr;
    memRdNext   = mem_rd;
    busyNext    = busy;
    doneNext    = 1'b0;
    validNext   = instr_valid;
    errNext     = fetch_err;
    instrNext   = instr;
    waitCntNext = waitCnt;

    unique case (state)
      IDLE: begin
        if (fetch_req) begin
          busyNext  = 1'b1;
          validNext = 1'b0;
          if (pc[1:0] == 2'b00) begin
            memAddrNext = pc;
            memRdNext   = 1'b1;
            errNext     = 1'b0;
            waitCntNext = '0;
            stateNext   = WAIT;
          end else begin
            // Misaligned: report without touching memory
            errNext   = 1'b1;
            instrNext = '0;
            doneNext  = 1'b1;
            stateNext = DONE;
          end
        end
      end
      WAIT: begin
        if (mem_ack) begin
          instrNext = mem_rdata;
          memRdNext = 1'b0;
          validNext = 1'b1;
          doneNext  = 1'b1;
          stateNext = DONE;
        end else if (waitCnt == CNT_LAST) begin
          // Timed out: load a NOP so downstream never sees stale data
          instrNext = '0;
          memRdNext = 1'b0;
          errNext   = 1'b1;
          doneNext  = 1'b1;
          stateNext = DONE;
        end else begin
          waitCntNext = waitCnt + CNT_W'(1);
        end
      end
      DONE: begin
        busyNext  = 1'b0;
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // Decoded views of the instruction register
  assign opcode = instr[31:26];
  assign rs     = instr[25:21];
  assign rt     = instr[20:16];
  assign rd     = instr[15:11];
  assign shamt  = instr[10:6];
  assign funct  = instr[5:0];
  assign imm16  = instr[15:0];
  assign jaddr  = instr[25:0];

endmodule

// File: tb/tb_instr_fetch_reg.sv
// Randomized bench for instr_fetch_reg: each fetch is predicted as a whole
// transaction (strobe length, done cycle, final register contents).
module tb_instr_fetch_reg;

  localparam int unsigned TO = 15;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_req;
  logic [31:0] pc;
  logic [31:0] mem_addr;
  logic        mem_rd;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        busy, done, instr_valid, fetch_err;
  logic [31:0] instr;
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm16;
  logic [25:0] jaddr;

  int assertCnt = 0;
  int failCnt   = 0;

  instr_fetch_reg #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .fetch_req(fetch_req), .pc(pc),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .busy(busy), .done(done), .instr_valid(instr_valid), .fetch_err(fetch_err),
    .instr(instr), .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt),
    .funct(funct), .imm16(imm16), .jaddr(jaddr)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    assertCnt++;
    if (got !== exp) begin
      failCnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic checkRegs(input string tag, input logic [31:0] expInstr, input bit expValid, input bit expErr);
    checkVal({tag, ".instr"},  64'(instr),       64'(expInstr));
    checkVal({tag, ".valid"},  64'(instr_valid), 64'(expValid));
    checkVal({tag, ".err"},    64'(fetch_err),   64'(expErr));
    checkVal({tag, ".opcode"}, 64'(opcode), 64'(expInstr >> 26));
    checkVal({tag, ".rs"},     64'(rs),     64'((expInstr >> 21) & 32'h1f));
    checkVal({tag, ".rt"},     64'(rt),     64'((expInstr >> 16) & 32'h1f));
    checkVal({tag, ".rd"},     64'(rd),     64'((expInstr >> 11) & 32'h1f));
    checkVal({tag, ".shamt"},  64'(shamt),  64'((expInstr >> 6) & 32'h1f));
    checkVal({tag, ".funct"},  64'(funct),  64'(expInstr & 32'h3f));
    checkVal({tag, ".imm16"},  64'(imm16),  64'(expInstr & 32'hffff));
    checkVal({tag, ".jaddr"},  64'(jaddr),  64'(expInstr & 32'h03ff_ffff));
  endtask

  // One fetch: request in cycle 0, ack driven in cycle ackDelay+1 (possibly after the
  // transaction ended, where it must be ignored). Called at posedge+1.
  task automatic runFetch(input string tag, input logic [31:0] fpc, input logic [31:0] rdata,
                          input int ackDelay, input bit extraReq);
    bit aligned, ok;
    int rdExp, doneExp, lastCyc;
    int rdCnt = 0, busyCnt = 0, doneCnt = 0, doneAt = -1, addrBad = 0, exclBad = 0;
    logic [31:0] expInstr;
    aligned  = (fpc % 4) == 0;
    ok       = aligned && (ackDelay < int'(TO));
    rdExp    = !aligned ? 0 : (ok ? ackDelay + 1 : int'(TO));
    doneExp  = rdExp + 1;
    expInstr = ok ? rdata : 32'h0;
    lastCyc  = ((doneExp > ackDelay + 1) ? doneExp : ackDelay + 1) + 2;

    fetch_req = 1'b1;
    pc        = fpc;
    for (int cyc = 1; cyc <= lastCyc; cyc++) begin
      nextCycle();
      if (mem_rd) begin
        rdCnt++;
        if (mem_addr !== fpc) addrBad++;
      end
      if (busy) busyCnt++;
      if (done) begin
        doneCnt++;
        doneAt = cyc;
      end
      if (instr_valid && fetch_err) exclBad++;
      fetch_req = extraReq && (cyc <= doneExp);
      pc        = fetch_req ? 32'h40 : fpc;
      mem_ack   = (cyc == ackDelay + 1);
      mem_rdata = mem_ack ? rdata : $urandom;
    end
    fetch_req = 1'b0;
    mem_ack   = 1'b0;

    checkVal({tag, ".rdCycles"},   64'(rdCnt),   64'(rdExp));
    checkVal({tag, ".busyCycles"}, 64'(busyCnt), 64'(doneExp));
    checkVal({tag, ".doneCount"},  64'(doneCnt), 64'd1);
    checkVal({tag, ".doneCycle"},  64'(doneAt),  64'(doneExp));
    checkVal({tag, ".addrStable"}, 64'(addrBad), 64'd0);
    checkVal({tag, ".exclusive"},  64'(exclBad), 64'd0);
    checkRegs(tag, expInstr, ok, !ok);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit extra;
    int dly;
    logic [31:0] rpc;

    reset = 1'b1; fetch_req = 1'b0; pc = '0; mem_ack = 1'b0; mem_rdata = '0;
    #1;
    checkVal("reset.mem_rd",   64'(mem_rd),   64'd0);
    checkVal("reset.mem_addr", 64'(mem_addr), 64'd0);
    checkVal("reset.busy",     64'(busy),     64'd0);
    checkVal("reset.done",     64'(done),     64'd0);
    checkRegs("reset", 32'h0, 1'b0, 1'b0);
    repeat (2) nextCycle();
    reset = 1'b0;
    nextCycle();

    runFetch("zeroWait",  32'h0000_0000, 32'h0800_0010, 0, 1'b0);
    runFetch("fiveWait",  32'h0000_0004, 32'h012A_4020, 5, 1'b0);
    runFetch("misalign",  32'h0000_0006, 32'h1234_5678, 0, 1'b0);
    runFetch("timeout",   32'h0000_0008, 32'hCAFE_F00D, TO + 1, 1'b0);
    runFetch("lastAck",   32'h0000_000C, 32'h8C42_FFFC, TO - 1, 1'b0);
    runFetch("reqDrop",   32'h0000_0010, 32'h2108_0001, 3, 1'b1);

    // Reset on the 3rd wait cycle, then a stray ack after release
    fetch_req = 1'b1; pc = 32'h0000_0100;
    nextCycle();
    fetch_req = 1'b0;
    repeat (2) nextCycle();
    reset = 1'b1;
    #1;
    checkVal("midReset.mem_rd", 64'(mem_rd), 64'd0);
    checkVal("midReset.busy",   64'(busy),   64'd0);
    checkRegs("midReset", 32'h0, 1'b0, 1'b0);
    nextCycle();
    reset = 1'b0;
    nextCycle();
    mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    nextCycle();
    mem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checkVal("lateAck.mem_rd", 64'(mem_rd), 64'd0);
      checkVal("lateAck.done",   64'(done),   64'd0);
      checkVal("lateAck.busy",   64'(busy),   64'd0);
      nextCycle();
    end
    checkRegs("lateAck", 32'h0, 1'b0, 1'b0);
    runFetch("afterReset", 32'h0000_0200, 32'h0000_0020, 1, 1'b0);

    for (int n = 0; n < 40; n++) begin
      rpc = 32'($urandom_range(0, 4095)) << 2;
      if ($urandom_range(0, 4) == 0) rpc = rpc | 32'($urandom_range(1, 3));
      dly   = int'($urandom_range(0, TO + 2));
      extra = 1'($urandom_range(0, 1));
      runFetch("rand", rpc, $urandom, dly, extra);
      repeat ($urandom_range(0, 2)) nextCycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCnt, failCnt);
    $finish;
  end

endmodule
